pwm_pulse_detect: RTL
=====================

Name: pwm_pulse_detect

Overview:
- Multi-channel hardware pulse-width detector. Replaces the software GPIO-sampling scheme, in which the Microblaze polls the PWM output through a GPIO input.
- For each channel, measures the high time and low time of a PWM input in sysclk cycles and presents the captured counts for axi_gpio readback.
- Sits in the top level between the PWM sources (axi_timer pwm0, or external Pmod pins) and the embedded system's GPIO inputs.

Parameters:
- NCH, 2, number of independent input channels (1..8)
- CNT_W, 24, width of each high/low counter and captured count
- FILT_CYC, 4, input stability length in cycles; used only when PWD_FILTER_EN is defined

Ports:
- sysclk  in  1  system clock, 100 MHz
- sysreset_n  in  1  synchronous active-low reset
- pwm_in  in  NCH  asynchronous PWM inputs, one bit per channel
- chan_en  in  NCH  per-channel enable; 0 = channel held idle
- valid_clr  in  NCH  single-cycle pulse; clears the corresponding valid bit
- high_cnt  out  NCH*CNT_W  captured high time; channel i occupies [i*CNT_W +: CNT_W]
- low_cnt  out  NCH*CNT_W  captured low time, packed the same way
- valid  out  NCH  sticky; 1 = new complete period captured since last clear
- stuck_hi  out  NCH  high counter saturated; input held high (treat as 100% duty)
- stuck_lo  out  NCH  low counter saturated; input held low (treat as 0% duty)

Behaviour:
- Clock and reset: one clock, sysclk. Reset is synchronous and active-low on sysreset_n. Reset clears every register: high_cnt=0, low_cnt=0, valid=0, stuck_hi=0, stuck_lo=0, synchronizers=0, internal counters=0, seen flags=0.
- Synchronization and edges: each pwm_in bit passes through a 2-FF synchronizer giving s. s_q is s delayed one cycle.
  - rise = s & ~s_q
  - fall = ~s & s_q
- High counter hc:
  - rise cycle: hc <= 1
  - other cycles with s=1: hc <= hc+1, saturating at 2^CNT_W-1
- Low counter lc: mirror of hc (fall cycle: lc <= 1; other cycles with s=0: lc <= lc+1, saturating).
- Capture:
  - fall cycle: high_cnt <= hc; set seen_hi.
  - rise cycle: low_cnt <= lc; set seen_lo.
  - Result: a steady input that is high H cycles and low L cycles yields exactly high_cnt=H and low_cnt=L.
- Valid:
  - set on a rise or fall capture cycle once both seen_hi and seen_lo are set, i.e. after the first full period; partial first phases are never flagged.
  - valid_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Latency: pin edge to updated output register = 3 sysclk cycles (2 synchronizer + 1 capture); +FILT_CYC when the filter is enabled.
- Saturation:
  - stuck_hi asserts in the cycle hc reaches 2^CNT_W-1 while s=1, and clears on the next fall.
  - stuck_lo is the mirror for lc.
  - A capture after saturation stores the saturated value.
- chan_en=0: counters, seen flags, valid and stuck bits are cleared and held. high_cnt and low_cnt keep their last values. On re-enable, measurement restarts as from reset; the first partial phase is discarded.
- Channels are fully independent; no cross-channel state.

Optional Feature:
- Macro PWD_FILTER_EN.
- Defined: between the synchronizer and edge detect, a per-channel stability filter.
  - The filtered level changes only after the synchronized input has held the new value for FILT_CYC consecutive cycles.
  - Pulses shorter than FILT_CYC cycles are ignored entirely.
  - Filter state resets to 0.
  - Counts are unchanged for clean inputs; only latency grows by FILT_CYC.
- Undefined: no filter logic; the synchronizer drives edge detect directly.

Test Plan:
- Reset: hold sysreset_n=0 for 5 cycles with pwm_in toggling -> all outputs 0; no valid until one full period after release.
- Steady PWM on ch0: high 300 cycles, low 700 cycles, chan_en=1 -> after the second rising edge, high_cnt[0]=300, low_cnt[0]=700, valid[0]=1. Ch1 outputs remain 0.
- Valid handshake: pulse valid_clr[0] in the same cycle as a capture -> valid[0] stays 1. Pulse it alone -> valid[0]=0 next cycle.
- Saturation with CNT_W=8: hold pwm_in[1]=1 for 300 cycles -> stuck_hi[1]=1 after 255 counted cycles. On release, high_cnt[1]=255 and stuck_hi[1] clears.
- Enable toggle: drop chan_en[0] mid-high-phase for 10 cycles, then restore -> valid[0]=0 and counts hold. The next valid reports only complete phases after re-enable.
- PWD_FILTER_EN with FILT_CYC=4: inject a 3-cycle glitch into a 500-cycle low phase -> low_cnt unaffected (500); a 4-cycle pulse is measured as high_cnt=4.

Source files
------------

// File: rtl/pwm_pulse_detect.sv
// pwm_pulse_detect
//   Multi-channel PWM pulse-width detector. For every channel the PWM input is
//   synchronized, optionally filtered, edge-detected, and the high and low
//   phase lengths are measured in sysclk cycles. The most recent completed
//   phase lengths are held for GPIO readback.
//
// Optional build macro:
//   PWD_FILTER_EN - inserts a per-channel stability filter (FILT_CYC cycles)
//                   between the synchronizer and the edge detector.
//
// Ports:
//   sysclk      system clock
//   sysreset_n  synchronous active-low reset
//   pwm_in      asynchronous PWM inputs, one bit per channel
//   chan_en     per-channel enable; 0 holds the channel idle
//   valid_clr   per-channel single-cycle pulse clearing valid
//   high_cnt    captured high time, channel i at [i*CNT_W +: CNT_W]
//   low_cnt     captured low time, packed the same way
//   valid       sticky flag: a complete period was captured since last clear
//   stuck_hi    high counter saturated (input held high)
//   stuck_lo    low counter saturated (input held low)

module pwm_pulse_detect #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 24,
  parameter int FILT_CYC = 4
) (
  input  logic                 sysclk,
  input  logic                 sysreset_n,
  input  logic [NCH-1:0]       pwm_in,
  input  logic [NCH-1:0]       chan_en,
  input  logic [NCH-1:0]       valid_clr,
  output logic [NCH*CNT_W-1:0] high_cnt,
  output logic [NCH*CNT_W-1:0] low_cnt,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       stuck_hi,
  output logic [NCH-1:0]       stuck_lo
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifndef PWD_FILTER_EN
  // FILT_CYC only matters when the filter is built; this empty block keeps
  // the parameter referenced in the unfiltered build.
  if (FILT_CYC < 0) begin : g_filt_unused
  end
`endif

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    logic             meta_reg;
    logic             sync_reg;
    logic             lvl;        // level seen by the edge detector
    logic             lvl_q_reg;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hc_reg;
    logic [CNT_W-1:0] lc_reg;
    logic [CNT_W-1:0] hc_next;
    logic [CNT_W-1:0] lc_next;
    logic [CNT_W-1:0] high_reg;
    logic [CNT_W-1:0] low_reg;
    logic             seen_hi_reg;
    logic             seen_lo_reg;
    logic             valid_reg;
    logic             stuck_hi_reg;
    logic             stuck_lo_reg;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge sysclk) begin
      if (!sysreset_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= pwm_in[gi];
        sync_reg <= meta_reg;
      end
    end

`ifdef PWD_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);
    logic          filt_reg;
    logic [FW-1:0] run_reg;

    // run_reg counts consecutive cycles the synchronized input has differed
    // from the filtered level; the level flips on the FILT_CYC-th such cycle,
    // so shorter pulses never reach the edge detector.
    always_ff @(posedge sysclk) begin
      if (!sysreset_n) begin
        filt_reg <= 1'b0;
        run_reg  <= '0;
      end else if (sync_reg == filt_reg) begin
        run_reg <= '0;
      end else if (run_reg == FW'(FILT_CYC - 1)) begin
        filt_reg <= sync_reg;
        run_reg  <= '0;
      end else begin
        run_reg <= run_reg + 1'b1;
      end
    end

    assign lvl = filt_reg;
`else
    assign lvl = sync_reg;
`endif

    assign rise = lvl & ~lvl_q_reg;
    assign fall = ~lvl & lvl_q_reg;

    // Saturating phase counters; each restarts at 1 on the edge opening its phase.
    assign hc_next = rise ? CNT_ONE :
                     (lvl ? ((hc_reg == CNT_MAX) ? CNT_MAX : hc_reg + 1'b1) : hc_reg);
    assign lc_next = fall ? CNT_ONE :
                     (!lvl ? ((lc_reg == CNT_MAX) ? CNT_MAX : lc_reg + 1'b1) : lc_reg);

    always_ff @(posedge sysclk) begin
      if (!sysreset_n) begin
        lvl_q_reg    <= 1'b0;
        hc_reg       <= '0;
        lc_reg       <= '0;
        high_reg     <= '0;
        low_reg      <= '0;
        seen_hi_reg  <= 1'b0;
        seen_lo_reg  <= 1'b0;
        valid_reg    <= 1'b0;
        stuck_hi_reg <= 1'b0;
        stuck_lo_reg <= 1'b0;
      end else begin
        // Edge history keeps tracking while disabled so re-enable does not
        // manufacture an edge.
        lvl_q_reg <= lvl;
        if (!chan_en[gi]) begin
          hc_reg       <= '0;
          lc_reg       <= '0;
          seen_hi_reg  <= 1'b0;
          seen_lo_reg  <= 1'b0;
          valid_reg    <= 1'b0;
          stuck_hi_reg <= 1'b0;
          stuck_lo_reg <= 1'b0;
        end else begin
          hc_reg <= hc_next;
          lc_reg <= lc_next;

          // A zero counter at capture means no cycle of that phase was
          // observed (edge right after reset/enable), so it does not count
          // as a seen phase.
          if (fall) begin
            high_reg <= hc_reg;
            if (hc_reg != '0) seen_hi_reg <= 1'b1;
          end
          if (rise) begin
            low_reg <= lc_reg;
            if (lc_reg != '0) seen_lo_reg <= 1'b1;
          end

          // Flags sampled before this capture: the first captured phase of
          // each polarity may be partial and is never reported as valid.
          if ((rise || fall) && seen_hi_reg && seen_lo_reg)
            valid_reg <= 1'b1;
          else if (valid_clr[gi])
            valid_reg <= 1'b0;

          if (fall)
            stuck_hi_reg <= 1'b0;
          else if (lvl && (hc_next == CNT_MAX))
            stuck_hi_reg <= 1'b1;

          if (rise)
            stuck_lo_reg <= 1'b0;
          else if (!lvl && (lc_next == CNT_MAX))
            stuck_lo_reg <= 1'b1;
        end
      end
    end

    assign high_cnt[gi*CNT_W +: CNT_W] = high_reg;
    assign low_cnt[gi*CNT_W +: CNT_W]  = low_reg;
    assign valid[gi]    = valid_reg;
    assign stuck_hi[gi] = stuck_hi_reg;
    assign stuck_lo[gi] = stuck_lo_reg;
  end

endmodule
